mux_n_pipe: RTL
===============

// Module: mux_n_pipe
// PURPOSE
//  Parametrised N-way, WIDTH-bit datapath selector with a registered, elastic output stage.
//  Replaces fixed 3-input combinational datapath muxes wherever the selected operand
//  crosses a pipeline boundary (ALU-src, PC-src, write-back select).
//  Adds a valid/ready handshake, 2-entry skid buffering and out-of-range selector handling.
// PARAMETERS
//  WIDTH    32  data width of every channel and of out_data
//  NUM_IN   3   number of input channels, 2..16
//  SEL_W    4   selector width; must satisfy 2**SEL_W >= NUM_IN
//  DEF_CH   0   channel used when selector >= NUM_IN
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             synchronous, active-high reset
//  data_in    in   NUM_IN*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//  selector   in   SEL_W         channel index, sampled with in_valid
//  in_valid   in   1             upstream holds data_in/selector valid
//  in_ready   out  1             block can accept this cycle
//  out_data   out  WIDTH         selected word, registered
//  out_sel    out  SEL_W         effective channel index that produced out_data
//  out_valid  out  1             out_data/out_sel valid
//  out_ready  in   1             downstream accepts this cycle
// BEHAVIOUR
//  - Clock clk, single domain; reset is synchronous and active-high, sampled on rising clk.
//  - Reset: out_valid=0, out_data=0, out_sel=0, in_ready=1 on the first edge; both entries empty.
//  - Accept when in_valid&&in_ready; emit when out_valid&&out_ready.
//  - Latency: accepted word appears on out_data the next cycle (1 cycle) when the buffer is empty.
//  - Throughput: 1 word/cycle while out_ready stays high.
//  - Select: sel_eff = (selector < NUM_IN) ? selector : DEF_CH.
//    Word = data_in[sel_eff*WIDTH +: WIDTH]. No X propagation for unused selector codes.
//  - Skid buffer: states EMPTY, ONE (main reg full), TWO (main + skid full).
//  - EMPTY: accept -> ONE.
//  - ONE:
//    - accept & emit -> ONE (main reloaded).
//    - accept & !emit -> TWO (word into skid).
//    - emit & !accept -> EMPTY.
//  - TWO: in_ready=0. emit -> ONE (skid moves to main); otherwise hold.
//  - in_ready is registered: 1 in EMPTY/ONE, 0 in TWO. It is not combinational from out_ready.
//  - Ordering is strictly FIFO; no word is dropped or duplicated.
//  - out_data/out_sel are stable while out_valid && !out_ready.
//  - Reset mid-transfer: all buffered words are discarded, returns to EMPTY; no emission that cycle.
// CONFIGURATION
//  Macro MUX_N_PIPE_SELERR_EN.
//  - Defined:
//    - Adds output port sel_err (1 bit), registered alongside out_data.
//    - sel_err=1 when the word's raw selector was >= NUM_IN.
//    - Adds output port sel_err_sticky, set on any such accept, cleared only by reset.
//  - Undefined: both ports absent; out-of-range selectors are silently mapped to DEF_CH.
// STRUCTURE
//  - Shared package mux_pkg:
//    - skid-state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
//    - clog2 helper function for SEL_W checks.
//  - Sub-module pipe_skid_buf: WIDTH-generic 2-entry valid/ready skid buffer.
//    mux_n_pipe = combinational select + pipe_skid_buf instance, payload width
//    WIDTH+SEL_W (+1 with SELERR_EN).
//  - Elaboration check: error if NUM_IN<2, NUM_IN>16, 2**SEL_W<NUM_IN or DEF_CH>=NUM_IN.
// TESTING
//  1 Reset:
//    - Stimulus: assert reset with in_valid=1.
//    - Expect: out_valid=0, out_data=0, in_ready=1 after the edge; nothing emitted.
//  2 Streaming:
//    - Stimulus: NUM_IN=3; ch0..2 = 0xA0,0xB1,0xC2; selector 0,1,2,0 on 4 back-to-back cycles;
//      out_ready=1.
//    - Expect: out_data A0,B1,C2,A0 on cycles 1..4; out_sel 0,1,2,0.
//  3 Backpressure:
//    - Stimulus: out_ready=0, send 3 words.
//    - Expect: word1 held on out_data; in_ready drops after word2; word3 waits.
//      Raise out_ready: order 1,2,3 with no loss.
//  4 Out of range:
//    - Stimulus: selector=7 (NUM_IN=3, DEF_CH=0).
//    - Expect: out_data=ch0, out_sel=0; with SELERR_EN, sel_err=1 and sel_err_sticky=1
//      until reset.
//  5 Mid-operation reset:
//    - Stimulus: buffer in TWO, assert reset for 1 cycle.
//    - Expect: out_valid=0 and in_ready=1 next cycle; the two buffered words never appear.
//  6 Random:
//    - Stimulus: random valid/ready/selector; NUM_IN=5, WIDTH=8; 10k cycles.
//    - Expect: scoreboard matches in-order; no X on out_data.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared skid-state encoding and sizing helper for mux_n_pipe
package mux_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - W-bit 2-entry valid/ready skid buffer with registered in_ready
module pipe_skid_buf
    import mux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         emit;

    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !emit)      state_nxt = ST_TWO;
                else if (emit && !accept) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (emit) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // in_ready follows the next state so it never depends on out_ready combinationally
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != ST_TWO);
            case (state)
                ST_EMPTY: if (accept) main_q <= in_data;
                ST_ONE: begin
                    if (accept && emit)       main_q <= in_data;
                    else if (accept && !emit) skid_q <= in_data;
                end
                ST_TWO:   if (emit) main_q <= skid_q;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - N-way registered elastic selector; MUX_N_PIPE_SELERR_EN adds sel_err/sel_err_sticky
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 4,
    parameter int DEF_CH = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        selector,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_N_PIPE_SELERR_EN
    ,
    output logic                    sel_err,
    output logic                    sel_err_sticky
`endif
);

    generate
        if (NUM_IN < 2 || NUM_IN > 16 || clog2(NUM_IN) > SEL_W || DEF_CH < 0 || DEF_CH >= NUM_IN) begin : g_bad_param
            $error("mux_n_pipe: illegal NUM_IN/SEL_W/DEF_CH combination");
        end
    endgenerate

`ifdef MUX_N_PIPE_SELERR_EN
    localparam int PW = WIDTH + SEL_W + 1;
`else
    localparam int PW = WIDTH + SEL_W;
`endif

    logic             raw_err;
    logic [SEL_W-1:0] sel_eff;
    logic [WIDTH-1:0] word;
    logic [PW-1:0]    pay_in;
    logic [PW-1:0]    pay_out;

    assign raw_err = !(int'(selector) < NUM_IN);
    assign sel_eff = raw_err ? SEL_W'(DEF_CH) : selector;

    // sel_eff is always a legal channel, so unused selector codes can never reach X data
    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel_eff) == k) word = data_in[k*WIDTH +: WIDTH];
        end
    end

`ifdef MUX_N_PIPE_SELERR_EN
    assign pay_in = {raw_err, sel_eff, word};
    assign {sel_err, out_sel, out_data} = pay_out;

    always_ff @(posedge clk) begin
        if (reset)                                 sel_err_sticky <= 1'b0;
        else if (in_valid && in_ready && raw_err)  sel_err_sticky <= 1'b1;
    end
`else
    assign pay_in = {sel_eff, word};
    assign {out_sel, out_data} = pay_out;
`endif

    pipe_skid_buf #(
        .W(PW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   (pay_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (pay_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule
